// File: rtl/player_move_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : player_move_ctrl_if
// Description : Bundle of the move request, map read port and reaction-logic
//               signals around the player movement controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface player_move_ctrl_if;
    logic        move_req;
    logic [1:0]  move_dir;
    logic        move_busy;
    logic        map_rd_en;
    logic [7:0]  map_rd_addr;
    logic [15:0] map_rd_data;
    logic [3:0]  goto_pos_x;
    logic [3:0]  goto_pos_y;
    logic [15:0] goto_tile_id;
    logic        goto_valid;
    logic [3:0]  new_pos_x;
    logic [3:0]  new_pos_y;
    logic [3:0]  pos_x;
    logic [3:0]  pos_y;
    logic        move_done;
    logic        moved;

    // Controller side: drives map reads, goto_* and the player position.
    modport master (
        input  move_req, move_dir, map_rd_data, new_pos_x, new_pos_y,
        output move_busy, map_rd_en, map_rd_addr, goto_pos_x, goto_pos_y,
               goto_tile_id, goto_valid, pos_x, pos_y, move_done, moved
    );

    // Environment side: direction decode, map RAM and reaction logic.
    modport slave (
        output move_req, move_dir, map_rd_data, new_pos_x, new_pos_y,
        input  move_busy, map_rd_en, map_rd_addr, goto_pos_x, goto_pos_y,
               goto_tile_id, goto_valid, pos_x, pos_y, move_done, moved
    );
endinterface
`default_nettype wire

// File: rtl/player_move_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : player_move_ctrl
// Description : Player movement front end. Computes the target cell of a move
//               request, reads its tile ID from the map, hands target and tile
//               to the reaction logic and commits the resolved position.
// Revision    : 1.0 - initial release
// ============================================================================
module player_move_ctrl #(
    parameter int MAP_W      = 16,
    parameter int MAP_H      = 16,
    parameter int START_X    = 0,
    parameter int START_Y    = 0,
    parameter int RD_LATENCY = 1
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    player_move_ctrl_if.master bus
);
    localparam logic [2:0] c_IDLE = 3'd0;
    localparam logic [2:0] c_READ = 3'd1;
    localparam logic [2:0] c_WAIT = 3'd2;
    localparam logic [2:0] c_EVAL = 3'd3;
    localparam logic [2:0] c_DONE = 3'd4;

    localparam logic [4:0] c_MAP_W   = 5'(MAP_W);
    localparam logic [4:0] c_MAP_H   = 5'(MAP_H);
    localparam logic [3:0] c_START_X = 4'(START_X);
    localparam logic [3:0] c_START_Y = 4'(START_Y);
    localparam logic [2:0] c_LAT_M1  = 3'(RD_LATENCY - 1);

    logic [2:0]  r_state;
    logic [2:0]  w_next;
    logic [3:0]  r_pos_x;
    logic [3:0]  r_pos_y;
    logic [3:0]  r_goto_x;
    logic [3:0]  r_goto_y;
    logic [15:0] r_tile;
    logic [2:0]  r_cnt;
    logic        r_moved;

    logic [4:0]  w_tx;
    logic [4:0]  w_ty;
    logic        w_inb;
    logic        w_rd_en;
    logic        w_goto_valid;
    logic        w_done;
    logic        w_busy;

    // Target cell in 5 bits so that 0-1 wraps to 31 and 15+1 reaches 16;
    // both then fail the unsigned bounds compare, so no wrap-around occurs.
    always_comb begin
        w_tx = {1'b0, r_pos_x};
        w_ty = {1'b0, r_pos_y};
        case (bus.move_dir)
            2'b00:   w_ty = {1'b0, r_pos_y} - 5'd1;
            2'b01:   w_ty = {1'b0, r_pos_y} + 5'd1;
            2'b10:   w_tx = {1'b0, r_pos_x} - 5'd1;
            default: w_tx = {1'b0, r_pos_x} + 5'd1;
        endcase
        w_inb = (w_tx < c_MAP_W) && (w_ty < c_MAP_H);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; requests outside IDLE are simply not looked at.
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE: if (bus.move_req) w_next = w_inb ? c_READ : c_DONE;
            c_READ: w_next = c_WAIT;
            c_WAIT: if (r_cnt == 3'd0) w_next = c_EVAL;
            c_EVAL: w_next = c_DONE;
            c_DONE: w_next = c_IDLE;
            default: w_next = c_IDLE;
        endcase
    end

    // State-decoded strobes.
    always_comb begin
        w_rd_en      = (r_state == c_READ);
        w_goto_valid = (r_state == c_EVAL);
        w_done       = (r_state == c_DONE);
        w_busy       = (r_state != c_IDLE);
    end

    // Datapath: target capture, read-latency count, tile capture, commit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pos_x  <= c_START_X;
            r_pos_y  <= c_START_Y;
            r_goto_x <= 4'd0;
            r_goto_y <= 4'd0;
            r_tile   <= 16'd0;
            r_cnt    <= 3'd0;
            r_moved  <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (bus.move_req) begin
                        r_goto_x <= w_tx[3:0];
                        r_goto_y <= w_ty[3:0];
                        r_moved  <= 1'b0;
                    end
                end
                c_READ: r_cnt <= c_LAT_M1;
                c_WAIT: begin
                    if (r_cnt == 3'd0) begin
                        r_tile <= bus.map_rd_data;
                    end else begin
                        r_cnt <= r_cnt - 3'd1;
                    end
                end
                c_EVAL: begin
                    r_pos_x <= bus.new_pos_x;
                    r_pos_y <= bus.new_pos_y;
                    r_moved <= (bus.new_pos_x != r_pos_x) ||
                               (bus.new_pos_y != r_pos_y);
                end
                default: ;
            endcase
        end
    end

    assign bus.move_busy    = w_busy;
    assign bus.map_rd_en    = w_rd_en;
    assign bus.map_rd_addr  = {r_goto_y, r_goto_x};
    assign bus.goto_pos_x   = r_goto_x;
    assign bus.goto_pos_y   = r_goto_y;
    assign bus.goto_tile_id = r_tile;
    assign bus.goto_valid   = w_goto_valid;
    assign bus.pos_x        = r_pos_x;
    assign bus.pos_y        = r_pos_y;
    assign bus.move_done    = w_done;
    assign bus.moved        = r_moved;
endmodule
`default_nettype wire

// File: tb/tb_player_move_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_player_move_ctrl
// Description : Scoreboard bench for player_move_ctrl. Two instances: A is
//               16x16 with read latency 1, B is 8x16 with read latency 3.
//               Both start at (3,5).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_player_move_ctrl;
    localparam logic [15:0] WALL = 16'h0007;

    typedef struct { int cyc; int addr; } rd_t;
    typedef struct { int cyc; int x; int y; int tile; } gt_t;
    typedef struct { int cyc; int moved; int x; int y; } dn_t;

    logic clk;
    logic rst_na;
    logic rst_nb;
    int   cyc;
    int   n_chk;
    int   n_err;

    logic [15:0] tiles [256];
    int mx [2];
    int my [2];
    int mw [2];
    int ml [2];

    rd_t qr0[$]; gt_t qg0[$]; dn_t qd0[$];
    rd_t qr1[$]; gt_t qg1[$]; dn_t qd1[$];

    player_move_ctrl_if ifa ();
    player_move_ctrl_if ifb ();

    player_move_ctrl #(.MAP_W(16), .MAP_H(16), .START_X(3), .START_Y(5), .RD_LATENCY(1))
        dut_a (.clk(clk), .rst_n(rst_na), .bus(ifa));
    player_move_ctrl #(.MAP_W(8), .MAP_H(16), .START_X(3), .START_Y(5), .RD_LATENCY(3))
        dut_b (.clk(clk), .rst_n(rst_nb), .bus(ifb));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Map RAM models; idle cycles return a marker so a mistimed capture shows.
    logic [15:0] pa;
    logic [15:0] pb [3];
    always @(posedge clk) begin
        pa    <= ifa.map_rd_en ? tiles[ifa.map_rd_addr] : 16'hDEAD;
        pb[0] <= ifb.map_rd_en ? tiles[ifb.map_rd_addr] : 16'hDEAD;
        pb[1] <= pb[0];
        pb[2] <= pb[1];
    end
    assign ifa.map_rd_data = pa;
    assign ifb.map_rd_data = pb[2];

    // Reaction logic: a wall keeps the player in place, anything else allows the move.
    assign ifa.new_pos_x = (ifa.goto_tile_id == WALL) ? ifa.pos_x : ifa.goto_pos_x;
    assign ifa.new_pos_y = (ifa.goto_tile_id == WALL) ? ifa.pos_y : ifa.goto_pos_y;
    assign ifb.new_pos_x = (ifb.goto_tile_id == WALL) ? ifb.pos_x : ifb.goto_pos_x;
    assign ifb.new_pos_y = (ifb.goto_tile_id == WALL) ? ifb.pos_y : ifb.goto_pos_y;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor body: every DUT event pops one expectation of its kind.
    task automatic mon(input int d, input logic en, input logic [7:0] addr,
                       input logic gv, input logic [3:0] gx, input logic [3:0] gy,
                       input logic [15:0] tid, input logic dn, input logic mv,
                       input logic [3:0] px, input logic [3:0] py);
        rd_t r; gt_t g; dn_t e;
        if (en === 1'b1) begin
            if ((d == 0 ? qr0.size() : qr1.size()) == 0) chk("rd_unexpected", 1, 0);
            else begin
                if (d == 0) r = qr0.pop_front(); else r = qr1.pop_front();
                chk("rd_cycle", cyc, r.cyc);
                chk("rd_addr", {24'd0, addr}, r.addr);
            end
        end
        if (gv === 1'b1) begin
            if ((d == 0 ? qg0.size() : qg1.size()) == 0) chk("goto_unexpected", 1, 0);
            else begin
                if (d == 0) g = qg0.pop_front(); else g = qg1.pop_front();
                chk("goto_cycle", cyc, g.cyc);
                chk("goto_x", {28'd0, gx}, g.x);
                chk("goto_y", {28'd0, gy}, g.y);
                chk("goto_tile", {16'd0, tid}, g.tile);
            end
        end
        if (dn === 1'b1) begin
            if ((d == 0 ? qd0.size() : qd1.size()) == 0) chk("done_unexpected", 1, 0);
            else begin
                if (d == 0) e = qd0.pop_front(); else e = qd1.pop_front();
                chk("done_cycle", cyc, e.cyc);
                chk("moved", {31'd0, mv}, e.moved);
                chk("pos_x", {28'd0, px}, e.x);
                chk("pos_y", {28'd0, py}, e.y);
            end
        end
    endtask

    always @(negedge clk) begin
        mon(0, ifa.map_rd_en, ifa.map_rd_addr, ifa.goto_valid, ifa.goto_pos_x,
            ifa.goto_pos_y, ifa.goto_tile_id, ifa.move_done, ifa.moved, ifa.pos_x, ifa.pos_y);
        mon(1, ifb.map_rd_en, ifb.map_rd_addr, ifb.goto_valid, ifb.goto_pos_x,
            ifb.goto_pos_y, ifb.goto_tile_id, ifb.move_done, ifb.moved, ifb.pos_x, ifb.pos_y);
    end

    task automatic set_req(input int d, input logic v, input logic [1:0] dir);
        if (d == 0) begin ifa.move_req = v; ifa.move_dir = dir; end
        else begin ifb.move_req = v; ifb.move_dir = dir; end
    endtask

    // Issue one move and push its expected read / goto / done events.
    task automatic issue(input int d, input logic [1:0] dir, input bit drop, input bit nowait);
        int tx, ty, c0, tile, nx, ny;
        logic [7:0] a;
        rd_t r; gt_t g; dn_t e;
        tx = mx[d]; ty = my[d];
        case (dir)
            2'b00:   ty = ty - 1;
            2'b01:   ty = ty + 1;
            2'b10:   tx = tx - 1;
            default: tx = tx + 1;
        endcase
        @(posedge clk); #1;
        c0 = cyc;
        set_req(d, 1'b1, dir);
        if (tx >= 0 && tx < mw[d] && ty >= 0 && ty < 16) begin
            a = 8'(ty * 16 + tx);
            tile = int'(tiles[a]);
            r = '{c0 + 1, int'(a)};
            g = '{c0 + 2 + ml[d], tx, ty, tile};
            if (tiles[a] == WALL) begin nx = mx[d]; ny = my[d]; end
            else begin nx = tx; ny = ty; end
            e = '{c0 + 3 + ml[d], (nx != mx[d] || ny != my[d]) ? 1 : 0, nx, ny};
            mx[d] = nx; my[d] = ny;
            if (d == 0) begin qr0.push_back(r); qg0.push_back(g); end
            else begin qr1.push_back(r); qg1.push_back(g); end
        end else begin
            e = '{c0 + 1, 0, mx[d], my[d]};
        end
        if (d == 0) qd0.push_back(e); else qd1.push_back(e);
        @(posedge clk); #1;
        chk("busy_cycle1", {31'd0, (d == 0) ? ifa.move_busy : ifb.move_busy}, 1);
        if (drop) begin
            @(posedge clk); #1;
            @(posedge clk); #1;
        end
        set_req(d, 1'b0, dir);
        if (!nowait) repeat (ml[d] + 4) @(posedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        cyc = 0; n_chk = 0; n_err = 0;
        mw[0] = 16; mw[1] = 8; ml[0] = 1; ml[1] = 3;
        mx[0] = 3; my[0] = 5; mx[1] = 3; my[1] = 5;
        for (int i = 0; i < 256; i++) tiles[i] = 16'h0000;
        tiles[8'h44] = WALL;
        tiles[8'h65] = 16'h0100;
        tiles[8'h7A] = 16'h0022;
        set_req(0, 1'b0, 2'b00);
        set_req(1, 1'b0, 2'b00);
        rst_na = 1'b1; rst_nb = 1'b1;
        #2 rst_na = 1'b0; rst_nb = 1'b0;
        #20;
        chk("rst_pos_x", {28'd0, ifa.pos_x}, 3);
        chk("rst_pos_y", {28'd0, ifa.pos_y}, 5);
        chk("rst_busy", {31'd0, ifa.move_busy}, 0);
        chk("rst_rd_en", {31'd0, ifa.map_rd_en}, 0);
        chk("rst_goto_valid", {31'd0, ifa.goto_valid}, 0);
        chk("rst_done", {31'd0, ifa.move_done}, 0);
        chk("rst_moved", {31'd0, ifa.moved}, 0);
        chk("rst_b_pos", {24'd0, ifb.pos_y, ifb.pos_x}, 8'h53);
        @(posedge clk); #1;
        rst_na = 1'b1; rst_nb = 1'b1;

        // Instance A: open move, wall, busy drop, walk to the edges.
        issue(0, 2'b11, 0, 0);
        issue(0, 2'b00, 0, 0);
        issue(0, 2'b01, 1, 0);
        repeat (4) issue(0, 2'b10, 0, 0);
        issue(0, 2'b01, 0, 0);
        issue(0, 2'b10, 0, 0);
        repeat (15) issue(0, 2'b11, 0, 0);
        issue(0, 2'b11, 0, 0);

        // Instance B: latency 3, narrow map edge, then reset abort in WAIT.
        repeat (4) issue(1, 2'b11, 0, 0);
        issue(1, 2'b11, 0, 0);
        issue(1, 2'b10, 0, 1);
        @(posedge clk); #1;
        rst_nb = 1'b0;
        qg1.delete();
        qd1.delete();
        mx[1] = 3; my[1] = 5;
        #1;
        chk("abort_busy", {31'd0, ifb.move_busy}, 0);
        chk("abort_pos", {24'd0, ifb.pos_y, ifb.pos_x}, 8'h53);
        chk("abort_done", {31'd0, ifb.move_done}, 0);
        repeat (2) @(posedge clk);
        #1 rst_nb = 1'b1;
        repeat (6) @(posedge clk);
        issue(1, 2'b11, 0, 0);

        repeat (4) @(posedge clk);
        chk("pending_a", qr0.size() + qg0.size() + qd0.size(), 0);
        chk("pending_b", qr1.size() + qg1.size() + qd1.size(), 0);
        chk("final_a_pos", {24'd0, ifa.pos_y, ifa.pos_x}, 8'h7F);
        chk("final_b_pos", {24'd0, ifb.pos_y, ifb.pos_x}, 8'h54);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
`default_nettype wire
